// File: rtl/step_clock_gen.sv
// step_clock_gen: tempo source for the sequencer. Turns a BPM request into a
// Step pulse train with a 16-step position index while Play is high. The
// step period is recomputed by a serial restoring divider on each tempo change.
module step_clock_gen #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned STEPS_PER_BEAT = 4,
  parameter int unsigned NUM_STEPS      = 16,
  parameter int unsigned BPM_MIN        = 40,
  parameter int unsigned BPM_MAX        = 240,
  parameter int unsigned PULSE_CYCLES   = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Play,
  input  logic [7:0] BPM,
  output logic       Step,
  output logic [3:0] StepIdx,
  output logic       BarStart,
  output logic       Busy
);

  // Clocks per minute divided by steps per beat; divided by BPM gives clocks per step.
  localparam logic [63:0] N_WIDE     = 64'(CLK_HZ) * 64'd60 / 64'(STEPS_PER_BEAT);
  localparam logic [31:0] N_DIV      = N_WIDE[31:0];
  localparam logic [31:0] PERIOD_120 = N_DIV / 32'd120;
  localparam logic [3:0]  LAST_IDX   = 4'(NUM_STEPS - 1);
  localparam logic [31:0] PULSE      = 32'(PULSE_CYCLES);

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
  typedef enum logic       {S_IDLE, S_RUN}               step_state_t;

  div_state_t  div_state;
  step_state_t step_state;

  logic [7:0]  bpm_clamped;
  logic [7:0]  bpm_latched;
  logic [31:0] dividend_q;   // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [31:0] rem_q;
  logic [4:0]  bit_cnt;
  logic [31:0] next_period;
  logic [32:0] rem_shift;
  logic [32:0] rem_sub;

  logic [31:0] period;
  logic [31:0] cnt;

  // Clamp the tempo request into the supported range
  always_comb begin
    bpm_clamped = BPM;
    if (BPM < 8'(BPM_MIN))
      bpm_clamped = 8'(BPM_MIN);
    else if (BPM > 8'(BPM_MAX))
      bpm_clamped = 8'(BPM_MAX);
  end

  // Trial subtraction for one restoring-divider step; borrow in bit 32 means "does not fit"
  always_comb begin
    rem_shift = {rem_q, dividend_q[31]};
    rem_sub   = rem_shift - {25'd0, bpm_latched};
  end

  // Divider FSM: latch a changed tempo, run 32 quotient bits, publish next_period
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_state   <= DIV_IDLE;
      bpm_latched <= 8'd120;
      dividend_q  <= '0;
      rem_q       <= '0;
      bit_cnt     <= '0;
      next_period <= PERIOD_120;
      Busy        <= 1'b0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (bpm_clamped != bpm_latched) begin
            bpm_latched <= bpm_clamped;
            dividend_q  <= N_DIV;
            rem_q       <= '0;
            bit_cnt     <= '0;
            Busy        <= 1'b1;
            div_state   <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          if (!rem_sub[32]) begin
            rem_q      <= rem_sub[31:0];
            dividend_q <= {dividend_q[30:0], 1'b1};
          end else begin
            rem_q      <= rem_shift[31:0];
            dividend_q <= {dividend_q[30:0], 1'b0};
          end
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31)
            div_state <= DIV_DONE;
        end
        DIV_DONE: begin
          next_period <= dividend_q;
          Busy        <= 1'b0;
          div_state   <= DIV_IDLE;
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  // Step FSM: count clocks per step, issue Step/BarStart, adopt new tempo only at step boundaries
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      step_state <= S_IDLE;
      period     <= PERIOD_120;
      cnt        <= '0;
      StepIdx    <= '0;
      Step       <= 1'b0;
      BarStart   <= 1'b0;
    end else begin
      case (step_state)
        S_IDLE: begin
          Step     <= 1'b0;
          BarStart <= 1'b0;
          if (Play) begin
            step_state <= S_RUN;
            period     <= next_period;
            cnt        <= '0;
            StepIdx    <= '0;
            Step       <= 1'b1;
            BarStart   <= 1'b1;
          end
        end
        S_RUN: begin
          if (!Play) begin
            step_state <= S_IDLE;
            Step       <= 1'b0;
            BarStart   <= 1'b0;
            StepIdx    <= '0;
            cnt        <= '0;
          end else if (cnt == period - 32'd1) begin
            cnt      <= '0;
            StepIdx  <= (StepIdx == LAST_IDX) ? 4'd0 : StepIdx + 4'd1;
            Step     <= 1'b1;
            BarStart <= (StepIdx == LAST_IDX);
            period   <= next_period;
          end else begin
            cnt      <= cnt + 32'd1;
            Step     <= ((cnt + 32'd1) < PULSE);
            BarStart <= 1'b0;
          end
        end
        default: step_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_clock_gen.sv
// tb_step_clock_gen: directed tempo scenarios plus randomized BPM/Play/Reset
// stimulus, checked every cycle against a timestamp-based tempo model.
module tb_step_clock_gen;

  localparam int unsigned CLK_HZ = 1600;
  localparam int unsigned SPB    = 4;
  localparam int unsigned NSTEPS = 16;
  localparam int unsigned PULSE  = 4;
  localparam int unsigned N      = CLK_HZ * 60 / SPB;   // 24000

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Play;
  logic [7:0] BPM;
  logic       Step;
  logic [3:0] StepIdx;
  logic       BarStart;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  step_clock_gen #(
    .CLK_HZ        (CLK_HZ),
    .STEPS_PER_BEAT(SPB),
    .NUM_STEPS     (NSTEPS),
    .BPM_MIN       (40),
    .BPM_MAX       (240),
    .PULSE_CYCLES  (PULSE)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Play    (Play),
    .BPM     (BPM),
    .Step    (Step),
    .StepIdx (StepIdx),
    .BarStart(BarStart),
    .Busy    (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: step rises are timestamps, tempo is plain division with a fixed latency
  longint      cyc = 0;
  bit          m_run;
  longint      m_rise;
  int unsigned m_period;
  int unsigned m_idx;
  int unsigned m_next;
  int unsigned m_lat;
  bit          m_bar;
  bit          m_busy;
  longint      m_div_end;
  bit          chk_en = 1'b0;

  function automatic int unsigned clampb(input int unsigned b);
    if (b < 40)  return 40;
    if (b > 240) return 240;
    return b;
  endfunction

  task automatic model_reset();
    m_run    = 1'b0;
    m_rise   = 0;
    m_period = N / 120;
    m_idx    = 0;
    m_next   = N / 120;
    m_lat    = 120;
    m_bar    = 1'b0;
    m_busy   = 1'b0;
  endtask

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      model_reset();
    end else begin
      cyc++;
      m_bar = 1'b0;
      if (!m_run) begin
        if (Play) begin
          m_run = 1'b1; m_period = m_next; m_rise = cyc; m_idx = 0; m_bar = 1'b1;
        end
      end else if (!Play) begin
        m_run = 1'b0; m_idx = 0;
      end else if (cyc - m_rise == longint'(m_period)) begin
        m_rise = cyc; m_idx = (m_idx + 1) % NSTEPS; m_period = m_next; m_bar = (m_idx == 0);
      end
      if (m_busy) begin
        if (cyc == m_div_end) begin
          m_next = N / m_lat; m_busy = 1'b0;
        end
      end else if (clampb(BPM) != m_lat) begin
        m_lat = clampb(BPM); m_busy = 1'b1; m_div_end = cyc + 33;
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en && !Reset) begin
      check_eq("step",     32'(Step),     32'(m_run && (cyc - m_rise) < PULSE));
      check_eq("step_idx", 32'(StepIdx),  m_idx);
      check_eq("bar",      32'(BarStart), 32'(m_bar));
      check_eq("busy",     32'(Busy),     32'(m_busy));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic wait_rise(output bit seen, output longint t);
    logic prev;
    seen = 1'b0;
    t    = cyc;
    prev = Step;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clock);
      if (!prev && Step) begin
        seen = 1'b1;
        t    = cyc;
        break;
      end
      prev = Step;
    end
  endtask

  task automatic measure_period(input string tag, input int unsigned exp);
    bit seen1, seen2;
    longint t1, t2;
    wait_rise(seen1, t1);
    wait_rise(seen2, t2);
    check_eq({tag, "_seen"}, 32'(seen1 && seen2), 32'd1);
    check_eq(tag, 32'(t2 - t1), exp);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_step"}, 32'(Step), 32'd0);
    check_eq({tag, "_idx"},  32'(StepIdx), 32'd0);
    check_eq({tag, "_bar"},  32'(BarStart), 32'd0);
    check_eq({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    bit     seen;
    longint t, tprev, c0;
    int     n;

    Reset = 1'b1; Play = 1'b0; BPM = 8'd120;
    tick(3);
    #1 check_all_zero("reset");
    tick(1);
    Reset  = 1'b0;
    chk_en = 1'b1;
    tick(2);

    // First step 1 clk after Play, PULSE clocks wide
    Play = 1'b1; c0 = cyc;
    tick(1);
    check_eq("first_lat", 32'(cyc - c0), 32'd1);
    check_eq("first_step", 32'(Step), 32'd1);
    check_eq("first_bar", 32'(BarStart), 32'd1);
    tprev = cyc;
    tick(3);
    check_eq("pulse_last", 32'(Step), 32'd1);
    tick(1);
    check_eq("pulse_end", 32'(Step), 32'd0);

    // 17 steps total: index sequence, bar strobes, 200-clock spacing
    for (int k = 1; k <= 16; k++) begin
      wait_rise(seen, t);
      check_eq("seq_seen", 32'(seen), 32'd1);
      check_eq("seq_period", 32'(t - tprev), 32'd200);
      check_eq("seq_idx", 32'(StepIdx), 32'(k % 16));
      check_eq("seq_bar", 32'(BarStart), 32'(k % 16 == 0));
      tprev = t;
    end

    // Tempo change mid-step: current step keeps old period
    tick(50);
    BPM = 8'd240;
    tick(1);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      tick(1);
    end
    check_eq("busy_len_ok", 32'(n >= 32 && n <= 34), 32'd1);
    wait_rise(seen, t);
    check_eq("old_period", 32'(t - tprev), 32'd200);
    tprev = t;
    wait_rise(seen, t);
    check_eq("new_period", 32'(t - tprev), 32'd100);

    // Clamp boundaries
    BPM = 8'd0;
    wait_rise(seen, t);
    measure_period("period_bpm0", 600);
    BPM = 8'd255;
    wait_rise(seen, t);
    measure_period("period_bpm255", 100);

    // Play dropped 2 clks after a rise, then re-raised
    wait_rise(seen, t);
    tick(1);
    Play = 1'b0;
    tick(1);
    check_eq("stop_step", 32'(Step), 32'd0);
    check_eq("stop_idx", 32'(StepIdx), 32'd0);
    Play = 1'b1;
    tick(1);
    check_eq("restart_step", 32'(Step), 32'd1);
    check_eq("restart_idx", 32'(StepIdx), 32'd0);
    check_eq("restart_bar", 32'(BarStart), 32'd1);

    // Reset during a divide: quotient in flight must be discarded
    BPM = 8'd60;
    tick(10);
    check_eq("busy_mid", 32'(Busy), 32'd1);
    #2 Reset = 1'b1; BPM = 8'd120;
    #1 check_all_zero("rst_div");
    tick(2);
    Reset = 1'b0;
    measure_period("period_after_rst", 200);

    // Reset during a Step pulse
    wait_rise(seen, t);
    #2 Reset = 1'b1;
    #1 check_all_zero("rst_pulse");
    tick(2);
    Reset = 1'b0;
    tick(5);

    // Randomized tempo, transport and reset activity
    for (int i = 0; i < 40; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        BPM = 8'($urandom_range(0, 255));
      end else if (r < 8) begin
        Play = ~Play;
      end else if (r == 8) begin
        #($urandom_range(1, 8)) Reset = 1'b1;
        #1 check_all_zero("rnd_rst");
        tick(1);
        Reset = 1'b0;
      end
      tick(int'($urandom_range(1, 700)));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
